alu_share_arbiter: RTL and testbench

// Shares one combinational ALU (5-bit ALUControl, 32-bit result, 4-bit nzcv) between two requesters.

---
 rtl/alu_share_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter sharing one external combinational ALU.
// Each grant runs IDLE -> EXEC -> RESP; the result is held until the owner accepts it.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic [FLAG_W-1:0] rsp0_nzcv,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic [FLAG_W-1:0] rsp1_nzcv,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_nzcv,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [CTRL_W-1:0] op_ctrl_q, op_ctrl_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0] rsp_nzcv_q, rsp_nzcv_d;
    logic              sel1;

    // Port 1 wins when alone, or on a tie when port 0 was served last.
    assign sel1 = req1_valid & (~req0_valid | ~last_grant_q);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_ctrl_d    = op_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_nzcv_d   = rsp_nzcv_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset && (req0_valid || req1_valid)) begin
                    req0_ready   = ~sel1;
                    req1_ready   = sel1;
                    grant_d      = sel1;
                    last_grant_d = sel1;
                    op_a_d       = sel1 ? req1_a    : req0_a;
                    op_b_d       = sel1 ? req1_b    : req0_b;
                    op_ctrl_d    = sel1 ? req1_ctrl : req0_ctrl;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_nzcv_d   = alu_nzcv;
                state_d      = RESP;
            end
            RESP: begin
                rsp0_valid = ~grant_q;
                rsp1_valid = grant_q;
                if (grant_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_ctrl_q    <= '0;
            rsp_result_q <= '0;
            rsp_nzcv_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_ctrl_q    <= op_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_nzcv_q   <= rsp_nzcv_d;
        end
    end

    assign alu_a       = op_a_q;
    assign alu_b       = op_b_q;
    assign alu_ctrl    = op_ctrl_q;
    assign rsp0_result = rsp_result_q;
    assign rsp0_nzcv   = rsp_nzcv_q;
    assign rsp1_result = rsp_result_q;
    assign rsp1_nzcv   = rsp_nzcv_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small add/sub/and ALU attached.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  rsp0_nzcv, rsp1_nzcv;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_ctrl;
    logic [3:0]  alu_nzcv;
    logic        busy;
    logic [32:0] sum;
    logic        cf, vf;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_nzcv(rsp0_nzcv),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_nzcv(rsp1_nzcv),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_nzcv(alu_nzcv), .busy(busy)
    );

    // Stand-in ALU: 00000 add, 10000 sub (C = no borrow), anything else AND.
    always_comb begin
        cf = 1'b0;
        vf = 1'b0;
        case (alu_ctrl)
            5'b00000: begin
                sum = {1'b0, alu_a} + {1'b0, alu_b};
                cf  = sum[32];
                vf  = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            5'b10000: begin
                sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                cf  = sum[32];
                vf  = (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]);
            end
            default: sum = {1'b0, alu_a & alu_b};
        endcase
        alu_result = sum[31:0];
        alu_nzcv   = {sum[31], sum[31:0] == 32'd0, cf, vf};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // One uncontended op on port p with both response readies high.
    task automatic run_op(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] c, input logic [31:0] er, input logic [3:0] en);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        if (p == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c;
        end
        #1;
        chk("op_req0_ready", req0_ready, p == 0);
        chk("op_req1_ready", req1_ready, p == 1);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("op_exec_busy", busy, 1);
        chk("op_exec_alu_a", alu_a, a);
        chk("op_exec_alu_ctrl", alu_ctrl, c);
        chk("op_exec_rsp_idle", {rsp0_valid, rsp1_valid}, 2'b00);
        cyc();
        #1;
        chk("op_rsp_valid", {rsp1_valid, rsp0_valid}, (p == 0) ? 2'b01 : 2'b10);
        chk("op_rsp_result", (p == 0) ? rsp0_result : rsp1_result, er);
        chk("op_rsp_nzcv", (p == 0) ? rsp0_nzcv : rsp1_nzcv, en);
        cyc();
        #1;
        chk("op_back_idle", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        cyc();
        cyc();
        // Reset state; ready must stay low even with a request pending.
        req0_valid = 1'b1;
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 2'b00);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        req0_valid = 1'b0;
        reset = 1'b0;

        // T1, T2 and flag/pass-through corners
        run_op(0, 32'd5, 32'd3, 5'b00000, 32'd8, 4'b0000);
        run_op(1, 32'd3, 32'd5, 5'b10000, 32'hFFFF_FFFE, 4'b1000);
        run_op(0, 32'd1, 32'hFFFF_FFFF, 5'b00000, 32'd0, 4'b0110);
        run_op(1, 32'h7FFF_FFFF, 32'd1, 5'b00000, 32'h8000_0000, 4'b1001);
        run_op(0, 32'hF0, 32'h3C, 5'b00011, 32'h30, 4'b0000);

        // T3: contention from reset alternates 0,1,0,1
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd10;  req0_b = 32'd20; req0_ctrl = 5'b00000;
        req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd1;  req1_ctrl = 5'b10000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_req0_ready", req0_ready, (k % 2) == 0);
            chk("rr_req1_ready", req1_ready, (k % 2) == 1);
            cyc();
            cyc();
            #1;
            chk("rr_rsp_valid", {rsp1_valid, rsp0_valid}, ((k % 2) == 0) ? 2'b01 : 2'b10);
            if ((k % 2) == 0) chk("rr_rsp0_result", rsp0_result, 32'd30);
            else chk("rr_rsp1_result", {rsp1_nzcv, rsp1_result}, {4'b0010, 32'd99});
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // T4: response backpressure holds everything stable
        #1;
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_ctrl = 5'b00000;
        #1;
        chk("bp_req0_ready", req0_ready, 1);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_rsp0_result", rsp0_result, 32'd4);
            chk("bp_req_ready", {req0_ready, req1_ready}, 2'b00);
            chk("bp_busy", busy, 1);
            cyc();
        end
        rsp0_ready = 1'b1;
        req1_valid = 1'b0;
        cyc();
        #1;
        chk("bp_released", {busy, rsp0_valid}, 2'b00);

        // T5: reset during a port-1 EXEC drops the op
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_ctrl = 5'b00000;
        #1;
        chk("rm_req1_ready", req1_ready, 1);
        cyc();
        #1;
        chk("rm_exec_busy", busy, 1);
        reset = 1'b1;
        req1_valid = 1'b0;
        cyc();
        #1;
        chk("rm_rsp1_valid_rst", rsp1_valid, 0);
        chk("rm_busy_rst", busy, 0);
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 5'b00000;
        req1_valid = 1'b1;
        #1;
        chk("rm_tie_ready", {req1_ready, req0_ready}, 2'b01);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();
        #1;
        chk("rm_after_rsp", {rsp1_valid, rsp0_valid, rsp0_result}, {2'b01, 32'd3});
        cyc();

        // T6: lone requester granted every third cycle
        do_reset();
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 5'b00000;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("solo_req0_ready", req0_ready, (i % 3) == 0);
            chk("solo_req1_ready", req1_ready, 0);
            cyc();
        end
        req0_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
